// File: rtl/core_pkg.sv
// Shared types for the 16-bit core: forwarding-mux encodings, hazard FSM states, shadow-stage records.
// Pure declarations; no latency or backpressure of its own.
package core_pkg;

    localparam int REG_AW = 4;

    typedef enum logic [1:0] {
        FWD_IDEX  = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'b00,
        HZ_LDSTALL = 2'b01,
        HZ_MEMWAIT = 2'b10
    } hz_state_t;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              uses_rs2;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              load;
        logic              mem;
    } idex_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              load;
        logic              mem;
    } exmem_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              we;
    } memwb_t;

    // True when a writing stage targets src; R0 never produces a value.
    function automatic logic reg_hit(input logic we, input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] src);
        return we && (rd != '0) && (rd == src);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand forward select for one EX source register; EX/MEM beats MEM/WB.
// Combinational, zero latency; no flow control.
module fwd_sel
    import core_pkg::*;
(
    input  logic [REG_AW-1:0] src_i,
    input  logic              en_i,
    input  exmem_t            exmem_i,
    input  memwb_t            memwb_i,
    output fwd_sel_t          sel_o
);

    always_comb begin
        sel_o = FWD_IDEX;
        if (en_i) begin
            // A load in EX/MEM has no data yet; the load-use bubble lets MEM/WB supply it.
            if (reg_hit(exmem_i.we, exmem_i.rd, src_i) && !exmem_i.load) begin
                sel_o = FWD_EXMEM;
            end else if (reg_hit(memwb_i.we, memwb_i.rd, src_i)) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects from shadowed ID/EX, EX/MEM, MEM/WB fields plus load-use / DM-wait sequencing.
// Selects are zero-latency from the shadows; a DM wait freezes the shadows, a load-use inserts one bubble.
module fwd_hazard_unit
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_load,
    input  logic              id_mem,
    input  logic              dm_ready,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              ifid_en,
    output logic              idex_bubble,
    output logic              pipe_freeze,
    output logic [1:0]        hz_state
);

    hz_state_t state_q, state_d;
    idex_t     idex_q,  idex_d;
    exmem_t    exmem_q, exmem_d;
    memwb_t    memwb_q, memwb_d;

    logic      mem_stall;
    logic      load_use;
    fwd_sel_t  fwd_a;
    fwd_sel_t  fwd_b;

    fwd_sel u_fwd_a (
        .src_i   (idex_q.rs1),
        .en_i    (1'b1),
        .exmem_i (exmem_q),
        .memwb_i (memwb_q),
        .sel_o   (fwd_a)
    );

    fwd_sel u_fwd_b (
        .src_i   (idex_q.rs2),
        .en_i    (idex_q.uses_rs2),
        .exmem_i (exmem_q),
        .memwb_i (memwb_q),
        .sel_o   (fwd_b)
    );

    assign ForwardA = fwd_a;
    assign ForwardB = fwd_b;
    assign hz_state = state_q;

    assign mem_stall = exmem_q.mem && !dm_ready;
    assign load_use  = id_valid && idex_q.load && (idex_q.rd != '0) &&
                       ((idex_q.rd == id_rs1) || (id_uses_rs2 && (idex_q.rd == id_rs2)));

    always_comb begin
        state_d     = state_q;
        ifid_en     = 1'b1;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        case (state_q)
            HZ_LDSTALL: begin
                if (mem_stall) begin
                    pipe_freeze = 1'b1;
                    ifid_en     = 1'b0;
                    state_d     = HZ_MEMWAIT;
                end else begin
                    state_d     = HZ_RUN;
                end
            end
            // RUN and MEMWAIT share one decision: a released wait is an ordinary RUN cycle.
            default: begin
                if (mem_stall) begin
                    pipe_freeze = 1'b1;
                    ifid_en     = 1'b0;
                    state_d     = HZ_MEMWAIT;
                end else if (load_use) begin
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    state_d     = HZ_LDSTALL;
                end else begin
                    state_d     = HZ_RUN;
                end
            end
        endcase
    end

    always_comb begin
        idex_d.rs1      = id_rs1;
        idex_d.rs2      = id_rs2;
        idex_d.uses_rs2 = id_uses_rs2;
        idex_d.rd       = id_rd;
        idex_d.we       = id_valid && id_we   && !idex_bubble;
        idex_d.load     = id_valid && id_load && !idex_bubble;
        idex_d.mem      = id_valid && id_mem  && !idex_bubble;

        exmem_d.rd      = idex_q.rd;
        exmem_d.we      = idex_q.we;
        exmem_d.load    = idex_q.load;
        exmem_d.mem     = idex_q.mem;

        memwb_d.rd      = exmem_q.rd;
        memwb_d.we      = exmem_q.we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HZ_RUN;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            state_q <= state_d;
            if (!pipe_freeze) begin
                idex_q  <= idex_d;
                exmem_q <= exmem_d;
                memwb_q <= memwb_d;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized and directed bench for fwd_hazard_unit against a stage-list pipeline model.
module tb_fwd_hazard_unit;

    typedef struct {
        logic       v;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       u;
        logic [3:0] rd;
        logic       we;
        logic       ld;
        logic       mem;
    } ins_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [3:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_uses_rs2 = 1'b0, id_we = 1'b0, id_load = 1'b0, id_mem = 1'b0;
    logic       dm_ready = 1'b1;
    logic [1:0] ForwardA, ForwardB, hz_state;
    logic       ifid_en, idex_bubble, pipe_freeze;

    fwd_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_we(id_we), .id_load(id_load), .id_mem(id_mem),
        .dm_ready(dm_ready), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .ifid_en(ifid_en), .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
        .hz_state(hz_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Model: the instruction records currently in EX, MEM and WB, plus what happened last cycle.
    ins_t m_ex, m_mm, m_wb;
    int   m_state;
    logic m_ifid;
    // Samples of the DUT from the latest step, for literal checks.
    int   s_fa, s_fb, s_ifid, s_bub, s_frz, s_hz;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ins_t nop();
        ins_t i;
        i = '{v: 1'b0, rs1: 4'd0, rs2: 4'd0, u: 1'b0, rd: 4'd0, we: 1'b0, ld: 1'b0, mem: 1'b0};
        return i;
    endfunction

    function automatic ins_t alu(input int rd, input int rs1, input int rs2);
        ins_t i;
        i = '{v: 1'b1, rs1: 4'(rs1), rs2: 4'(rs2), u: 1'b1, rd: 4'(rd), we: 1'b1, ld: 1'b0, mem: 1'b0};
        return i;
    endfunction

    function automatic ins_t ldi(input int rd, input int rs1);
        ins_t i;
        i = '{v: 1'b1, rs1: 4'(rs1), rs2: 4'd0, u: 1'b0, rd: 4'(rd), we: 1'b1, ld: 1'b1, mem: 1'b1};
        return i;
    endfunction

    function automatic ins_t sti(input int rs1, input int rs2);
        ins_t i;
        i = '{v: 1'b1, rs1: 4'(rs1), rs2: 4'(rs2), u: 1'b1, rd: 4'd0, we: 1'b0, ld: 1'b0, mem: 1'b1};
        return i;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t i;
        int k;
        k = int'($urandom_range(0, 3));
        if (k == 0)      i = ldi(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        else if (k == 1) i = sti(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        else begin
            i = alu(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
            i.u  = 1'($urandom_range(0, 1));
            i.we = ($urandom_range(0, 3) != 0);
        end
        if ($urandom_range(0, 7) == 0) begin
            i.v = 1'b0; i.we = 1'b0; i.ld = 1'b0; i.mem = 1'b0;
        end
        return i;
    endfunction

    // Newest older writer of src wins; a load one stage ahead cannot supply data.
    function automatic int mfwd(input logic [3:0] src);
        if (m_mm.we && m_mm.rd != 0 && m_mm.rd == src && !m_mm.ld) return 2;
        if (m_wb.we && m_wb.rd != 0 && m_wb.rd == src) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_ex = nop(); m_mm = nop(); m_wb = nop();
        m_state = 0;
        m_ifid = 1'b1;
    endtask

    task automatic step(input ins_t i, input logic rdy);
        logic frz, hz, bub;
        int   fa, fb;
        @(negedge clk);
        id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_uses_rs2 = i.u;
        id_rd = i.rd; id_we = i.we; id_load = i.ld; id_mem = i.mem;
        dm_ready = rdy;
        #1;
        frz = m_mm.mem && !rdy;
        hz  = i.v && m_ex.ld && m_ex.rd != 0 &&
              (m_ex.rd == i.rs1 || (i.u && m_ex.rd == i.rs2));
        bub = !frz && hz && (m_state != 1);
        fa  = mfwd(m_ex.rs1);
        fb  = m_ex.u ? mfwd(m_ex.rs2) : 0;
        s_fa = int'(ForwardA); s_fb = int'(ForwardB); s_ifid = int'(ifid_en);
        s_bub = int'(idex_bubble); s_frz = int'(pipe_freeze); s_hz = int'(hz_state);
        chk("ForwardA",    s_fa,   fa);
        chk("ForwardB",    s_fb,   fb);
        chk("pipe_freeze", s_frz,  int'(frz));
        chk("idex_bubble", s_bub,  int'(bub));
        chk("ifid_en",     s_ifid, int'(!frz && !bub));
        chk("hz_state",    s_hz,   m_state);
        m_ifid = !frz && !bub;
        if (!frz) begin
            m_wb = m_mm;
            m_mm = m_ex;
            m_ex = i;
            if (bub) begin m_ex.we = 1'b0; m_ex.ld = 1'b0; m_ex.mem = 1'b0; end
        end
        m_state = frz ? 2 : (bub ? 1 : 0);
    endtask

    initial begin
        ins_t cur;
        int   nbub;
        model_reset();
        #12;
        chk("reset ForwardA", int'(ForwardA), 0);
        chk("reset ForwardB", int'(ForwardB), 0);
        chk("reset ifid_en", int'(ifid_en), 1);
        chk("reset idex_bubble", int'(idex_bubble), 0);
        chk("reset pipe_freeze", int'(pipe_freeze), 0);
        chk("reset hz_state", int'(hz_state), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back ALU dependency.
        step(alu(1, 2, 3), 1'b1);
        step(alu(4, 1, 5), 1'b1);
        chk("alu pair no stall", s_ifid, 1);
        step(nop(), 1'b1);
        chk("alu pair A", s_fa, 2);
        chk("alu pair B", s_fb, 0);

        // Distance 2 and distance 3.
        step(alu(1, 2, 3), 1'b1);
        step(alu(8, 9, 10), 1'b1);
        step(alu(11, 12, 1), 1'b1);
        step(nop(), 1'b1);
        chk("dist2 B", s_fb, 1);
        step(alu(1, 2, 3), 1'b1);
        step(nop(), 1'b1);
        step(nop(), 1'b1);
        step(alu(11, 12, 1), 1'b1);
        step(nop(), 1'b1);
        chk("dist3 B", s_fb, 0);

        // Load-use: one bubble, then MEM/WB forwarding.
        step(ldi(6, 2), 1'b1);
        step(alu(7, 6, 6), 1'b1);
        chk("ldu ifid_en", s_ifid, 0);
        chk("ldu bubble", s_bub, 1);
        step(alu(7, 6, 6), 1'b1);
        chk("ldu hz_state", s_hz, 1);
        chk("ldu stall ifid_en", s_ifid, 1);
        chk("ldu stall bubble", s_bub, 0);
        step(nop(), 1'b1);
        chk("ldu A", s_fa, 1);
        chk("ldu B", s_fb, 1);

        // R0 never forwards; EX/MEM beats MEM/WB.
        step(alu(0, 1, 2), 1'b1);
        step(alu(3, 0, 0), 1'b1);
        step(nop(), 1'b1);
        chk("r0 A", s_fa, 0);
        chk("r0 B", s_fb, 0);
        step(alu(2, 1, 1), 1'b1);
        step(alu(2, 3, 3), 1'b1);
        step(alu(4, 2, 5), 1'b1);
        step(nop(), 1'b1);
        chk("priority A", s_fa, 2);

        // DM wait of three cycles with a load-use pending behind it.
        step(alu(5, 1, 1), 1'b1);
        step(sti(3, 4), 1'b1);
        step(ldi(6, 5), 1'b1);
        nbub = 0;
        for (int k = 0; k < 3; k++) begin
            step(alu(7, 6, 0), 1'b0);
            chk("wait freeze", s_frz, 1);
            chk("wait A held", s_fa, 1);
            chk("wait ifid_en", s_ifid, 0);
            nbub += s_bub;
        end
        chk("wait hz_state", s_hz, 2);
        step(alu(7, 6, 0), 1'b1);
        chk("release freeze", s_frz, 0);
        nbub += s_bub;
        step(alu(7, 6, 0), 1'b1);
        nbub += s_bub;
        step(nop(), 1'b1);
        nbub += s_bub;
        chk("release bubble count", nbub, 1);
        chk("release A", s_fa, 1);

        // Reset asserted during MEMWAIT.
        step(alu(1, 2, 2), 1'b1);
        step(sti(3, 4), 1'b1);
        step(nop(), 1'b1);
        step(nop(), 1'b0);
        step(nop(), 1'b0);
        chk("pre-reset hz_state", s_hz, 2);
        @(negedge clk);
        dm_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst hz_state", int'(hz_state), 0);
        chk("rst pipe_freeze", int'(pipe_freeze), 0);
        chk("rst ForwardA", int'(ForwardA), 0);
        chk("rst ForwardB", int'(ForwardB), 0);
        chk("rst ifid_en", int'(ifid_en), 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(alu(8, 1, 1), 1'b1);
        step(nop(), 1'b1);
        chk("post-reset A", s_fa, 0);
        chk("post-reset B", s_fb, 0);

        // Random traffic; IF/ID holds the ID instruction whenever the model says it must.
        cur = rnd_ins();
        for (int n = 0; n < 3000; n++) begin
            step(cur, ($urandom_range(0, 3) != 0));
            if (m_ifid) cur = rnd_ins();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Pipeline hazard and forwarding control for the 16-bit core. It shadows the destination-register fields of the ID/EX, EX/MEM and MEM/WB stages and drives the 2-bit `ForwardA`/`ForwardB` selects consumed by the EX-stage operand muxes. It also sequences load-use stalls and data-memory wait freezes with a small state machine. It sits beside the ID/EX register and gates the IF/ID and ID/EX enables.

## Interface
- `REG_AW`, 4: register-address width; address 0 is hardwired zero.
- `clk` input 1: pipeline clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `id_valid` input 1: the ID stage holds a real instruction.
- `id_rs1`, `id_rs2` input REG_AW: ID source registers.
- `id_uses_rs2` input 1: the ID instruction reads rs2.
- `id_rd` input REG_AW: ID destination register.
- `id_we` input 1: the ID instruction writes the register file.
- `id_load` input 1: the ID instruction is a DM load.
- `id_mem` input 1: the ID instruction is a DM load or store.
- `dm_ready` input 1: DM completes the access presented by EX/MEM this cycle.
- `ForwardA`, `ForwardB` output 2: operand selects for EX. 00 = ID/EX (register file), 10 = EX/MEM (prior ALU result), 01 = MEM/WB (DM or earlier ALU). 11 is never driven.
- `ifid_en` output 1: IF/ID (and PC) update enable.
- `idex_bubble` output 1: load NOP into ID/EX this cycle.
- `pipe_freeze` output 1: hold ID/EX, EX/MEM and MEM/WB.
- `hz_state` output 2: current FSM state, for debug.

## Operation
- Shadow stages: the ID/EX shadow holds rs1, rs2, uses_rs2, rd, we, load and mem. The EX/MEM shadow holds rd, we, load and mem. The MEM/WB shadow holds rd and we.
- Shadows advance every cycle unless `pipe_freeze` is high.
- A bubble clears `we`, `load` and `mem` in the ID/EX shadow.
- Forward select for operand X (rs1→A, rs2→B), evaluated on the ID/EX shadow:
  - 10 if exmem.we, exmem.rd≠0, exmem.rd==idex.rsX and not exmem.load.
  - Else 01 if memwb.we, memwb.rd≠0 and memwb.rd==idex.rsX.
  - Else 00.
  - EX/MEM has priority over MEM/WB.
  - If idex.uses_rs2 is 0, `ForwardB` = 00.
- Load-use hazard, combinational:
  - Condition: id_valid, idex.load, idex.rd≠0, and idex.rd matches id_rs1, or matches id_rs2 with id_uses_rs2.
  - A load in EX/MEM never needs forwarding from EX/MEM: the single bubble guarantees the consumer sees it from MEM/WB.
- FSM states: RUN=00, LDSTALL=01, MEMWAIT=10.
  - RUN:
    - exmem.mem && !dm_ready → MEMWAIT, with `pipe_freeze`=1 and `ifid_en`=0.
    - Else a load-use hazard → LDSTALL, with `ifid_en`=0 and `idex_bubble`=1.
    - Else stay in RUN, with `ifid_en`=1.
  - LDSTALL: lasts exactly one cycle with `ifid_en`=1 and no bubble, then → RUN.
    - If exmem.mem && !dm_ready in this cycle → MEMWAIT instead, and the freeze takes precedence.
  - MEMWAIT: `pipe_freeze`=1 and `ifid_en`=0 while !dm_ready.
    - When dm_ready=1, the same cycle is a normal RUN cycle: outputs are recomputed as in RUN and the state goes → RUN.
- Simultaneous memory wait and load-use: the freeze wins. The load-use hazard is re-evaluated after the freeze releases; no bubble is lost or duplicated.
- `ForwardA`/`ForwardB` are held stable during a freeze, because the shadows are frozen.

## Timing
- Forward selects are combinational from the shadow registers. They are valid in the same cycle the instruction occupies EX, with zero latency.
- Load-use: one bubble cycle. The consumer enters EX two cycles after the load and receives `ForwardX`=01.
- Back-to-back ALU dependency: 10 with no stall.
- Dependency at distance 2: 01.
- Dependency at distance 3 or more: 00, because the register file writes first and reads second.
- Reset, asynchronous while `rst_n`=0:
  - All shadow we/load/mem bits and all rd fields are cleared to 0.
  - The state is RUN.
  - Outputs: `ForwardA`=`ForwardB`=00, `ifid_en`=1, `idex_bubble`=0, `pipe_freeze`=0, `hz_state`=00.
- Reset asserted mid-stall or mid-wait drops straight to RUN with empty shadows. Reset release is synchronous to the design by upstream logic.

## Structure
- The shared package `core_pkg` holds:
  - The `fwd_sel_t` encodings FWD_IDEX=2'b00, FWD_EXMEM=2'b10 and FWD_MEMWB=2'b01. The operand muxes reuse these.
  - The `hz_state_t` enum.
  - `REG_AW`.
- One sub-module is natural: `fwd_sel`, a combinational compare of one source address against the EX/MEM and MEM/WB shadows. It is instantiated twice, for A and B.

## Test plan
- ALU pair: R1←R2+R3, then R4←R1+R5 → the second instruction in EX sees `ForwardA`=10 and `ForwardB`=00, with no stall.
- Distance 2: R1 write, independent instruction, then read R1 as rs2 → `ForwardB`=01. At distance 3 → 00.
- Load-use: LD R6, then ADD R7←R6+R6 → one cycle with `ifid_en`=0 and `idex_bubble`=1, `hz_state` 01. Next cycle ADD is in EX with `ForwardA`=`ForwardB`=01.
- R0 and priority:
  - Write R0, then read R0 → 00.
  - R2 written in both EX/MEM and MEM/WB → 10.
- DM wait: a store in EX/MEM with dm_ready low for 3 cycles → `pipe_freeze`=1 for 3 cycles and the forward selects held. A load-use pending in ID then produces exactly one bubble after release.
- Reset: assert `rst_n`=0 during MEMWAIT → immediately `hz_state`=00, `pipe_freeze`=0, forwards 00. After release, no stale forwarding occurs.
